dmac_ahb_slave_mem: RTL and testbench

DMAC_AHB_SLAVE_MEM -- requirements
Module: dmac_ahb_slave_mem

---
 rtl/dmac_ahb_slave_mem_if.sv | 23 ++
 rtl/dmac_ahb_slave_mem.sv | 129 ++++++++++++
 tb/tb_dmac_ahb_slave_mem.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmac_ahb_slave_mem_if.sv
// AHB-lite slave bus bundle for the DMAC scratch memory.
interface dmac_ahb_slave_mem_if;
    logic        HSel;
    logic [31:0] HAddr;
    logic [1:0]  HTrans;
    logic        HWrite;
    logic [31:0] HWData;
    logic [3:0]  HWStrb;
    logic        HReady;
    logic [31:0] HRData;
    logic        HReadyOut;
    logic [1:0]  HResp;

    modport master (
        output HSel, HAddr, HTrans, HWrite, HWData, HWStrb, HReady,
        input  HRData, HReadyOut, HResp
    );

    modport slave (
        input  HSel, HAddr, HTrans, HWrite, HWData, HWStrb, HReady,
        output HRData, HReadyOut, HResp
    );
endinterface

// File: rtl/dmac_ahb_slave_mem.sv
// AHB-lite word memory with optional data-phase wait states and two-cycle ERROR response.
// Optional feature macro: DMAC_SLV_WAIT_EN (compiles in the WAIT state and wait counter).
module dmac_ahb_slave_mem #(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic                  clk,
    input logic                  rst,
    dmac_ahb_slave_mem_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
    localparam int unsigned CNT_W = 4;

    if (WAIT_STATES > 15) begin : g_ws_range
        $error("WAIT_STATES must be in 0..15");
    end

`ifdef DMAC_SLV_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;
`endif

    state_t             state, state_n;
    logic [IDX_W-1:0]   cap_idx;
    logic               cap_write;
    logic [31:0]        mem [DEPTH];

    logic [31:0]        offset_c;
    logic               legal_c, ready_c, accept_c, done_c, mem_we_c;

    assign offset_c = bus.HAddr - BASE_ADDR;
    assign legal_c  = (offset_c < SPAN) && (bus.HAddr[1:0] == 2'b00);

`ifdef DMAC_SLV_WAIT_EN
    logic [CNT_W-1:0] cnt, cnt_n;
    assign done_c  = (state == WAIT) && (cnt == '0);
    assign ready_c = (state != ERR1) && !((state == WAIT) && (cnt != '0));
`else
    // Without wait states a legal data phase is a single completion cycle tracked by pend.
    logic pend, pend_n;
    assign done_c  = pend;
    assign ready_c = (state != ERR1);
`endif

    assign accept_c = bus.HSel && bus.HTrans[1] && bus.HReady && ready_c;
    assign mem_we_c = !rst && done_c && cap_write;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
`ifdef DMAC_SLV_WAIT_EN
            cnt   <= '0;
`else
            pend  <= 1'b0;
`endif
        end else begin
            state <= state_n;
`ifdef DMAC_SLV_WAIT_EN
            cnt   <= cnt_n;
`else
            pend  <= pend_n;
`endif
        end
    end

    // Next state: a new address phase is only taken in a cycle where this slave is ready
    always_comb begin
        state_n = state;
`ifdef DMAC_SLV_WAIT_EN
        cnt_n   = cnt;
`else
        pend_n  = 1'b0;
`endif
        if (ready_c) begin
            state_n = IDLE;
            if (accept_c) begin
                if (legal_c) begin
`ifdef DMAC_SLV_WAIT_EN
                    state_n = WAIT;
                    cnt_n   = CNT_W'(WAIT_STATES);
`else
                    pend_n  = 1'b1;
`endif
                end else begin
                    state_n = ERR1;
                end
            end
        end else begin
            case (state)
                ERR1:    state_n = ERR2;
`ifdef DMAC_SLV_WAIT_EN
                WAIT:    cnt_n   = cnt - CNT_W'(1);
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    // Address-phase capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_idx   <= '0;
            cap_write <= 1'b0;
        end else if (accept_c) begin
            cap_idx   <= IDX_W'(offset_c >> 2);
            cap_write <= bus.HWrite;
        end
    end

    // Byte-enabled write on the completion edge; array is never reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.HWStrb[b]) begin
                    mem[cap_idx][8*b +: 8] <= bus.HWData[8*b +: 8];
                end
            end
        end
    end

    assign bus.HReadyOut = rst || ready_c;
    assign bus.HResp     = (!rst && ((state == ERR1) || (state == ERR2))) ? 2'b01 : 2'b00;
    assign bus.HRData    = (!rst && done_c && !cap_write) ? mem[cap_idx] : 32'h0;

endmodule

// File: tb/tb_dmac_ahb_slave_mem.sv
// Self-checking bench: per-cycle expectation queue model plus directed transfers.
module tb_dmac_ahb_slave_mem;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WS    = 2;
`ifdef DMAC_SLV_WAIT_EN
    localparam int unsigned EFF_WS = WS;
`else
    localparam int unsigned EFF_WS = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmac_ahb_slave_mem_if bus ();

    dmac_ahb_slave_mem #(
        .DEPTH       (DEPTH),
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // One expected data-phase cycle
    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        logic        rd;
        logic        wr;
        int unsigned idx;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    exp_t        idle_e;
    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  known_m [DEPTH];
    logic [31:0] exp_rd, rd_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand one accepted address phase into its expected data-phase cycles
    task automatic push_phase(input logic [31:0] addr, input logic wr);
        logic [31:0] off;
        off = addr - BASE;
        if ((off < 32'(DEPTH * 4)) && (addr % 4 == 0)) begin
            for (int k = 0; k < int'(EFF_WS); k++)
                q.push_back('{rdy: 1'b0, resp: 2'b00, rd: 1'b0, wr: 1'b0, idx: 0});
            q.push_back('{rdy: 1'b1, resp: 2'b00, rd: !wr, wr: wr, idx: off / 4});
        end else begin
            q.push_back('{rdy: 1'b0, resp: 2'b01, rd: 1'b0, wr: 1'b0, idx: 0});
            q.push_back('{rdy: 1'b1, resp: 2'b01, rd: 1'b0, wr: 1'b0, idx: 0});
        end
    endtask

    // Compare process: every cycle, away from the rising edge
    always @(negedge clk) begin
        if (rst) begin
            cur = idle_e;
            q.delete();
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else begin
            cur = idle_e;
        end
        exp_rd  = 32'h0;
        rd_mask = 32'hFFFF_FFFF;
        if (cur.rd) begin
            exp_rd  = mem_m[cur.idx];
            rd_mask = {{8{known_m[cur.idx][3]}}, {8{known_m[cur.idx][2]}},
                       {8{known_m[cur.idx][1]}}, {8{known_m[cur.idx][0]}}};
        end
        chk("cyc_HReadyOut", 32'(bus.HReadyOut), 32'(cur.rdy));
        chk("cyc_HResp", 32'(bus.HResp), 32'(cur.resp));
        chk("cyc_HRData", bus.HRData & rd_mask, exp_rd & rd_mask);
        if (!rst && cur.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.HWStrb[b]) begin
                    mem_m[cur.idx][8*b +: 8] = bus.HWData[8*b +: 8];
                    known_m[cur.idx][b]      = 1'b1;
                end
            end
        end
        if (!rst && bus.HSel && bus.HTrans[1] && bus.HReady && cur.rdy)
            push_phase(bus.HAddr, bus.HWrite);
    end

    // Wait (bounded) for the completion cycle of the current data phase
    task automatic wait_done(input string name, output int waits, output logic [31:0] rdata);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = 32'h0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.HReadyOut) begin
                done  = 1'b1;
                rdata = bus.HRData;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got HReadyOut low for %0d cycles expected completion", name, waits);
        end
    endtask

    // Single NONSEQ transfer from an idle bus
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output int waits);
        bus.HSel   = 1'b1;
        bus.HTrans = 2'b10;
        bus.HWrite = wr;
        bus.HAddr  = addr;
        @(posedge clk); #1;
        bus.HSel   = 1'b0;
        bus.HTrans = 2'b00;
        bus.HWData = wdata;
        bus.HWStrb = strb;
        wait_done("xfer", waits, rdata);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    int          w, w1, w2;

    initial begin
        idle_e = '{rdy: 1'b1, resp: 2'b00, rd: 1'b0, wr: 1'b0, idx: 0};
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_m[i]   = 32'h0;
            known_m[i] = 4'h0;
        end
        rst        = 1'b1;
        bus.HSel   = 1'b0;
        bus.HAddr  = 32'h0;
        bus.HTrans = 2'b00;
        bus.HWrite = 1'b0;
        bus.HWData = 32'h0;
        bus.HWStrb = 4'h0;
        bus.HReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_HReadyOut", 32'(bus.HReadyOut), 32'h1);
        chk("reset_HRData", bus.HRData, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Wait-state write then read back
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, w);
        chk("w10_waits", 32'(w), 32'(EFF_WS));
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, w);
        chk("r10_data", rd, 32'hDEADBEEF);

        // Pipelined write 0x20 then read 0x20
        bus.HSel = 1'b1; bus.HTrans = 2'b10; bus.HWrite = 1'b1; bus.HAddr = 32'h20;
        @(posedge clk); #1;
        bus.HWData = 32'h12345678; bus.HWStrb = 4'hF;
        bus.HWrite = 1'b0; bus.HAddr = 32'h20;
        wait_done("b2b_wr", w1, rd);
        @(posedge clk); #1;
        bus.HSel = 1'b0; bus.HTrans = 2'b00;
        wait_done("b2b_rd", w2, rd);
        @(posedge clk); #1;
        chk("b2b_wr_waits", 32'(w1), 32'(EFF_WS));
        chk("b2b_rd_waits", 32'(w2), 32'(EFF_WS));
        chk("b2b_rd_data", rd, 32'h12345678);

        // Partial strobes
        xfer(1'b1, 32'h30, 32'hAABBCCDD, 4'hF, rd, w);
        xfer(1'b1, 32'h30, 32'h11223344, 4'b0101, rd, w);
        xfer(1'b0, 32'h30, 32'h0, 4'h0, rd, w);
        chk("r30_strb", rd, 32'hAA22CC44);

        // Out-of-range and misaligned accesses leave memory untouched
        xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, w);
        xfer(1'b1, 32'h400, 32'h55555555, 4'hF, rd, w);
        chk("err400_waits", 32'(w), 32'h1);
        xfer(1'b1, 32'h2, 32'h66666666, 4'hF, rd, w);
        chk("err2_waits", 32'(w), 32'h1);
        xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, w);
        chk("r0_after_err", rd, 32'hCAFEF00D);

        // Last legal word
        xfer(1'b1, 32'h3FC, 32'h0BADC0DE, 4'hF, rd, w);
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0, rd, w);
        chk("r3fc_data", rd, 32'h0BADC0DE);

        // Reset during a write data phase aborts it
        xfer(1'b1, 32'h40, 32'h01020304, 4'hF, rd, w);
        bus.HSel = 1'b1; bus.HTrans = 2'b10; bus.HWrite = 1'b1; bus.HAddr = 32'h40;
        @(posedge clk); #1;
        bus.HSel = 1'b0; bus.HTrans = 2'b00;
        bus.HWData = 32'hFFFFFFFF; bus.HWStrb = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_HReadyOut", 32'(bus.HReadyOut), 32'h1);
        chk("post_rst_HResp", 32'(bus.HResp), 32'h0);
        xfer(1'b0, 32'h40, 32'h0, 4'h0, rd, w);
        chk("r40_after_rst", rd, 32'h01020304);

        // HReady low blocks capture
        bus.HSel = 1'b1; bus.HTrans = 2'b10; bus.HWrite = 1'b1; bus.HAddr = 32'h10;
        bus.HReady = 1'b0; bus.HWData = 32'h0; bus.HWStrb = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        bus.HSel = 1'b0; bus.HTrans = 2'b00; bus.HReady = 1'b1;
        @(posedge clk); #1;

        // BUSY while selected is an idle transfer
        bus.HSel = 1'b1; bus.HTrans = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        bus.HSel = 1'b0; bus.HTrans = 2'b00;

        // Zero strobes complete without change
        xfer(1'b1, 32'h10, 32'h0, 4'h0, rd, w);
        chk("w10_nostrb_waits", 32'(w), 32'(EFF_WS));
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, w);
        chk("r10_unchanged", rd, 32'hDEADBEEF);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
